coffee_payment_ctrl: RTL and testbench
======================================

Name: coffee_payment_ctrl

Overview:
Payment and selection front-end for the coffee dispenser FSM. It accumulates coin credit, validates the customer's drink selection against per-drink prices, and issues the selection code and a one-cycle go pulse downstream. It then waits for the dispenser to complete and returns change. It sits directly upstream of the dispenser; its drink_sel/drink_go outputs drive the dispenser's in/go inputs.

Parameters:
CW, 8, credit/price/change width in bits (units of 1 cent)
PRICE_A, 25, price of drink A (code 2'b00)
PRICE_B, 35, price of drink B (code 2'b01)
PRICE_C, 50, price of drink C (code 2'b10)
MAX_CREDIT, 200, credit ceiling; must be < 2**CW
DONE_TIMEOUT, 64, cycles to wait for disp_done before faulting

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
coin_valid  in  1  one coin presented this cycle
coin_type  in  2  00=5, 01=10, 10=25, 11=100 cents
sel_valid  in  1  selection button strobe
sel  in  2  00=A, 01=B, 10=C, 11=invalid
cancel  in  1  refund request
disp_done  in  1  dispenser finished the cup (1-cycle pulse)
drink_sel  out  2  selection code to dispenser
drink_go  out  1  one-cycle vend start pulse
coin_reject  out  1  one-cycle pulse, coin returned
sel_denied  out  1  one-cycle pulse, selection refused
change_valid  out  1  one-cycle pulse, change_amt valid
change_amt  out  CW  change/refund amount
credit  out  CW  current credit (registered)
busy  out  1  high in VEND, WAIT_DONE, CHANGE
fault  out  1  sticky; set on dispenser timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; credit=0; drink_sel=2'b00; change_amt=0; fault=0; all pulses and busy=0.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, WAIT_DONE, CHANGE. All outputs are registered.
- Coin in IDLE/COLLECT: if credit+value <= MAX_CREDIT, then credit += value and the state goes to COLLECT. Otherwise, coin_reject pulses next cycle and credit is unchanged. Coins arriving in VEND/WAIT_DONE/CHANGE are always rejected.
- Selection in IDLE/COLLECT is evaluated against the credit registered before this cycle's coin; a coin in the same cycle is still accepted normally.
  - If sel==11 or credit < price: sel_denied pulses and the state is unchanged.
  - Otherwise: latch drink_sel=sel and price, go to VEND.
- VEND: drink_go=1 for exactly one cycle (the first cycle of VEND), then WAIT_DONE.
- WAIT_DONE: on disp_done, go to CHANGE. A disp_done seen in any other state is ignored. A counter counts cycles in WAIT_DONE. When it reaches DONE_TIMEOUT without disp_done: fault=1 (sticky until reset), change_amt=full credit, change_valid pulses, credit=0, go to IDLE.
- CHANGE (one cycle): change_amt=credit-price. change_valid=1 only if the difference is nonzero. credit=0, go to IDLE.
- cancel in COLLECT: change_amt=credit, change_valid pulses, credit=0, go to IDLE.
  - cancel outranks sel_valid and coin_valid in the same cycle; the coin is rejected and the selection is ignored without sel_denied.
  - cancel in IDLE does nothing. cancel in VEND/WAIT_DONE/CHANGE is ignored.
- When fault=1, every selection is denied; coins and cancel still operate.
- change_amt holds its last value between pulses.
- Reset asserted mid-vend aborts immediately with no refund.

Test Plan:
1. Reset, coin 25, sel=A -> credit=25; drink_sel=00, drink_go pulses one cycle later; after disp_done, no change_valid; credit=0, IDLE.
2. Coins 25+25, sel=B, disp_done after 5 cycles -> drink_go once; change_valid with change_amt=15; busy high from VEND through CHANGE.
3. Coin 10, sel=C -> sel_denied pulse, credit stays 10; then cancel -> change_valid with change_amt=10; credit=0.
4. Coin 100 twice, then coin 5 -> credit=200, coin_reject pulse, credit stays 200; a coin during WAIT_DONE -> coin_reject.
5. Coin 25 and sel=A in the same cycle with credit=0 -> sel_denied, credit=25. Coin 10 and cancel in the same cycle -> coin_reject, refund 25.
6. Credit 50, sel=A, no disp_done for 64 cycles -> fault=1, change_valid with change_amt=50; a later sel with enough credit -> sel_denied. Async reset mid-WAIT_DONE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/coffee_payment_ctrl.sv
// Coffee dispenser payment front-end.
// Collects coin credit, validates selection, starts vend, returns change.
module coffee_payment_ctrl #(
  parameter int CW           = 8,
  parameter int PRICE_A      = 25,
  parameter int PRICE_B      = 35,
  parameter int PRICE_C      = 50,
  parameter int MAX_CREDIT   = 200,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic          sel_valid,
  input  logic [1:0]    sel,
  input  logic          cancel,
  input  logic          disp_done,
  output logic [1:0]    drink_sel,
  output logic          drink_go,
  output logic          coin_reject,
  output logic          sel_denied,
  output logic          change_valid,
  output logic [CW-1:0] change_amt,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          fault
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CHANGE  = 3'd4;

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CW:0]   MAXC  = (CW+1)'(MAX_CREDIT);
  localparam logic [CW-1:0] PA    = CW'(PRICE_A);
  localparam logic [CW-1:0] PB    = CW'(PRICE_B);
  localparam logic [CW-1:0] PC    = CW'(PRICE_C);
  localparam logic [TW-1:0] TLAST = TW'(DONE_TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_price;
  logic [TW-1:0] r_cnt;

  logic [CW:0]   w_coin_val;
  logic [CW:0]   w_sum;
  logic          w_coin_ok;
  logic [CW-1:0] w_price;
  logic          w_sel_ok;

  // Decode coin value and selected drink price.
  always_comb begin
    w_coin_val = '0;
    w_price    = '0;
    case (coin_type)
      2'b00:   w_coin_val = (CW+1)'(5);
      2'b01:   w_coin_val = (CW+1)'(10);
      2'b10:   w_coin_val = (CW+1)'(25);
      default: w_coin_val = (CW+1)'(100);
    endcase
    case (sel)
      2'b00:   w_price = PA;
      2'b01:   w_price = PB;
      default: w_price = PC;
    endcase
  end

  assign w_sum     = {1'b0, credit} + w_coin_val;
  assign w_coin_ok = (w_sum <= MAXC);
  assign w_sel_ok  = !fault && (sel != 2'b11) && (credit >= w_price);

  // Main FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_price      <= '0;
      r_cnt        <= '0;
      credit       <= '0;
      drink_sel    <= 2'b00;
      drink_go     <= 1'b0;
      coin_reject  <= 1'b0;
      sel_denied   <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      drink_go     <= 1'b0;
      coin_reject  <= 1'b0;
      sel_denied   <= 1'b0;
      change_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (cancel && r_state == S_COLLECT) begin
            change_amt   <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            coin_reject  <= coin_valid;
            r_state      <= S_IDLE;
          end else begin
            if (coin_valid) begin
              if (w_coin_ok) begin
                credit  <= w_sum[CW-1:0];
                r_state <= S_COLLECT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
            if (sel_valid) begin
              if (w_sel_ok) begin
                drink_sel <= sel;
                r_price   <= w_price;
                drink_go  <= 1'b1;
                busy      <= 1'b1;
                r_state   <= S_VEND;
              end else begin
                sel_denied <= 1'b1;
              end
            end
          end
        end
        S_VEND: begin
          coin_reject <= coin_valid;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          coin_reject <= coin_valid;
          if (disp_done) begin
            r_state <= S_CHANGE;
          end else if (r_cnt == TLAST) begin
            fault        <= 1'b1;
            change_amt   <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHANGE: begin
          coin_reject  <= coin_valid;
          change_amt   <= credit - r_price;
          change_valid <= (credit != r_price);
          credit       <= '0;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coffee_payment_ctrl.sv
// Directed testbench for coffee_payment_ctrl.
// Hand-computed expectations, one task per scenario.
module tb_coffee_payment_ctrl;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_done;
  logic [1:0] drink_sel;
  logic       drink_go;
  logic       coin_reject;
  logic       sel_denied;
  logic       change_valid;
  logic [7:0] change_amt;
  logic [7:0] credit;
  logic       busy;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;

  coffee_payment_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .disp_done    (disp_done),
    .drink_sel    (drink_sel),
    .drink_go     (drink_go),
    .coin_reject  (coin_reject),
    .sel_denied   (sel_denied),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .busy         (busy),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
    disp_done  = 1'b0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    coin_valid = 0; coin_type = 0; sel_valid = 0;
    sel = 0; cancel = 0; disp_done = 0;
    #2;
    n_cmp++;
    if ({credit, change_amt, drink_sel} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_vals got cr=%0d ch=%0d ds=%0d want 0",
               credit, change_amt, drink_sel);
    end
    n_cmp++;
    if ({drink_go, coin_reject, sel_denied, change_valid, busy, fault}
        !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000000",
               {drink_go, coin_reject, sel_denied, change_valid, busy, fault});
    end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_exact_vend();
    coin(2'b10);
    n_cmp++;
    if (credit !== 8'd25) begin
      n_err++; $display("FAIL t1_credit got %0d want 25", credit);
    end
    sel_valid = 1; sel = 2'b00;
    cyc();
    n_cmp++;
    if ({drink_go, drink_sel, busy} !== 4'b1001) begin
      n_err++;
      $display("FAIL t1_go got go=%b ds=%b busy=%b want 1 00 1",
               drink_go, drink_sel, busy);
    end
    cyc();
    n_cmp++;
    if ({drink_go, busy} !== 2'b01) begin
      n_err++; $display("FAIL t1_wait got go=%b busy=%b want 0 1",
                        drink_go, busy);
    end
    disp_done = 1;
    cyc();
    cyc();
    n_cmp++;
    if ({change_valid, busy} !== 2'b00 || credit !== 8'd0 ||
        change_amt !== 8'd0) begin
      n_err++;
      $display("FAIL t1_done got cv=%b busy=%b cr=%0d ch=%0d want 0 0 0 0",
               change_valid, busy, credit, change_amt);
    end
  endtask

  task automatic test_change();
    int gos;
    coin(2'b10); coin(2'b10);
    sel_valid = 1; sel = 2'b01;
    cyc();
    gos = drink_go ? 1 : 0;
    n_cmp++;
    if (drink_sel !== 2'b01 || busy !== 1'b1) begin
      n_err++; $display("FAIL t2_sel got ds=%b busy=%b want 01 1",
                        drink_sel, busy);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (drink_go) gos++;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL t2_busy got %b want 1 (i=%0d)", busy, i);
      end
    end
    n_cmp++;
    if (gos !== 1) begin
      n_err++; $display("FAIL t2_gocount got %0d want 1", gos);
    end
    disp_done = 1;
    cyc();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL t2_busy_change got %b want 1", busy);
    end
    cyc();
    n_cmp++;
    if (change_valid !== 1'b1 || change_amt !== 8'd15 ||
        credit !== 8'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t2_change got cv=%b ch=%0d cr=%0d busy=%b want 1 15 0 0",
               change_valid, change_amt, credit, busy);
    end
    cyc();
    n_cmp++;
    if (change_valid !== 1'b0 || change_amt !== 8'd15) begin
      n_err++;
      $display("FAIL t2_hold got cv=%b ch=%0d want 0 15",
               change_valid, change_amt);
    end
  endtask

  task automatic test_deny_cancel();
    coin(2'b01);
    sel_valid = 1; sel = 2'b10;
    cyc();
    n_cmp++;
    if (sel_denied !== 1'b1 || credit !== 8'd10 || drink_go !== 1'b0) begin
      n_err++;
      $display("FAIL t3_deny got sd=%b cr=%0d go=%b want 1 10 0",
               sel_denied, credit, drink_go);
    end
    sel_valid = 1; sel = 2'b11;
    cyc();
    n_cmp++;
    if (sel_denied !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL t3_invalid got sd=%b busy=%b want 1 0",
                        sel_denied, busy);
    end
    cancel = 1;
    cyc();
    n_cmp++;
    if (change_valid !== 1'b1 || change_amt !== 8'd10 ||
        credit !== 8'd0) begin
      n_err++;
      $display("FAIL t3_cancel got cv=%b ch=%0d cr=%0d want 1 10 0",
               change_valid, change_amt, credit);
    end
    cancel = 1;
    cyc();
    n_cmp++;
    if (change_valid !== 1'b0 || change_amt !== 8'd10) begin
      n_err++; $display("FAIL t3_idle_cancel got cv=%b ch=%0d want 0 10",
                        change_valid, change_amt);
    end
  endtask

  task automatic test_ceiling();
    coin(2'b11); coin(2'b11);
    n_cmp++;
    if (credit !== 8'd200 || coin_reject !== 1'b0) begin
      n_err++; $display("FAIL t4_max got cr=%0d rj=%b want 200 0",
                        credit, coin_reject);
    end
    coin(2'b00);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 8'd200) begin
      n_err++; $display("FAIL t4_reject got rj=%b cr=%0d want 1 200",
                        coin_reject, credit);
    end
    sel_valid = 1; sel = 2'b00;
    cyc();
    cyc();
    coin(2'b01);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 8'd200 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL t4_busy_coin got rj=%b cr=%0d busy=%b want 1 200 1",
               coin_reject, credit, busy);
    end
    disp_done = 1;
    cyc();
    cyc();
    n_cmp++;
    if (change_valid !== 1'b1 || change_amt !== 8'd175) begin
      n_err++; $display("FAIL t4_change got cv=%b ch=%0d want 1 175",
                        change_valid, change_amt);
    end
    disp_done = 1;
    cyc();
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0) begin
      n_err++;
      $display("FAIL t4_idle_done got busy=%b cv=%b cr=%0d want 0 0 0",
               busy, change_valid, credit);
    end
  endtask

  task automatic test_same_cycle();
    coin_valid = 1; coin_type = 2'b10;
    sel_valid = 1; sel = 2'b00;
    cyc();
    n_cmp++;
    if (sel_denied !== 1'b1 || credit !== 8'd25 || drink_go !== 1'b0) begin
      n_err++;
      $display("FAIL t5_coin_sel got sd=%b cr=%0d go=%b want 1 25 0",
               sel_denied, credit, drink_go);
    end
    coin_valid = 1; coin_type = 2'b01;
    sel_valid = 1; sel = 2'b00;
    cancel = 1;
    cyc();
    n_cmp++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 ||
        change_amt !== 8'd25 || credit !== 8'd0 || sel_denied !== 1'b0) begin
      n_err++;
      $display("FAIL t5_cancel got rj=%b cv=%b ch=%0d cr=%0d sd=%b want 1 1 25 0 0",
               coin_reject, change_valid, change_amt, credit, sel_denied);
    end
    coin(2'b10);
    coin_valid = 1; coin_type = 2'b01;
    sel_valid = 1; sel = 2'b00;
    cyc();
    n_cmp++;
    if (drink_go !== 1'b1 || credit !== 8'd35) begin
      n_err++; $display("FAIL t5_vend_coin got go=%b cr=%0d want 1 35",
                        drink_go, credit);
    end
    cyc();
    disp_done = 1;
    cyc();
    cyc();
    n_cmp++;
    if (change_valid !== 1'b1 || change_amt !== 8'd10) begin
      n_err++; $display("FAIL t5_change got cv=%b ch=%0d want 1 10",
                        change_valid, change_amt);
    end
  endtask

  task automatic test_timeout_reset();
    int n;
    bit hit;
    coin(2'b10); coin(2'b10);
    sel_valid = 1; sel = 2'b00;
    cyc();
    hit = 0;
    n = 0;
    for (int i = 1; i <= 80 && !hit; i++) begin
      cyc();
      n = i;
      if (change_valid) hit = 1;
    end
    n_cmp++;
    if (!hit || n !== 65) begin
      n_err++; $display("FAIL t6_timeout got hit=%b cycles=%0d want 1 65",
                        hit, n);
    end
    n_cmp++;
    if (fault !== 1'b1 || change_amt !== 8'd50 || credit !== 8'd0 ||
        busy !== 1'b0) begin
      n_err++;
      $display("FAIL t6_fault got f=%b ch=%0d cr=%0d busy=%b want 1 50 0 0",
               fault, change_amt, credit, busy);
    end
    coin(2'b10); coin(2'b10);
    sel_valid = 1; sel = 2'b00;
    cyc();
    n_cmp++;
    if (sel_denied !== 1'b1 || drink_go !== 1'b0 || fault !== 1'b1 ||
        credit !== 8'd50) begin
      n_err++;
      $display("FAIL t6_deny got sd=%b go=%b f=%b cr=%0d want 1 0 1 50",
               sel_denied, drink_go, fault, credit);
    end
    cancel = 1;
    cyc();
    n_cmp++;
    if (change_valid !== 1'b1 || change_amt !== 8'd50) begin
      n_err++; $display("FAIL t6_refund got cv=%b ch=%0d want 1 50",
                        change_valid, change_amt);
    end
    rst = 0;
    #1;
    n_cmp++;
    if (fault !== 1'b0) begin
      n_err++; $display("FAIL t6_fault_clr got %b want 0", fault);
    end
    cyc();
    rst = 1;
    coin(2'b10);
    sel_valid = 1; sel = 2'b10;
    coin_valid = 1; coin_type = 2'b10;
    cyc();
    sel_valid = 1; sel = 2'b10;
    cyc();
    cyc();
    n_cmp++;
    if (busy !== 1'b1 || drink_sel !== 2'b10) begin
      n_err++; $display("FAIL t6_pre_rst got busy=%b ds=%b want 1 10",
                        busy, drink_sel);
    end
    #2;
    rst = 0;
    #1;
    n_cmp++;
    if ({credit, change_amt, drink_sel} !== 18'd0 ||
        {drink_go, coin_reject, sel_denied, change_valid, busy, fault}
        !== 6'b0) begin
      n_err++;
      $display("FAIL t6_async_rst got cr=%0d ch=%0d ds=%b busy=%b cv=%b want 0",
               credit, change_amt, drink_sel, busy, change_valid);
    end
    cyc();
    rst = 1;
    disp_done = 1;
    cyc();
    cyc();
    n_cmp++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
      n_err++;
      $display("FAIL t6_after_rst got cv=%b busy=%b cr=%0d want 0 0 0",
               change_valid, busy, credit);
    end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_change();
    test_deny_cancel();
    test_ceiling();
    test_same_cycle();
    test_timeout_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
